ldst_mem_arbiter: RTL and testbench

LDST_MEM_ARBITER -- requirements
Module: ldst_mem_arbiter

---
 rtl/ldst_pkg.sv | 24 ++
 rtl/ldst_rr_lock.sv | 67 ++++++
 rtl/ldst_mem_arbiter.sv | 89 ++++++++
 tb/tb_ldst_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ldst_pkg.sv
// Shared types for the load/store memory arbiter: lock state, port id and the
// registered read-return tag that steers rdata back to the owning port.
package ldst_pkg;

    typedef enum logic [0:0] {
        LK_UNLOCKED  = 1'b0,
        LK_LOCKED_P1 = 1'b1
    } lock_state_t;

    typedef logic [0:0] port_id_t;

    localparam port_id_t PORT_P0 = 1'b0;
    localparam port_id_t PORT_P1 = 1'b1;

    typedef struct packed {
        logic     vld;
        port_id_t port;
    } rtag_t;

    function automatic port_id_t oh_to_port(input logic [1:0] oh);
        return (oh == 2'b10) ? PORT_P1 : PORT_P0;
    endfunction

endpackage

// File: rtl/ldst_rr_lock.sv
// Two-port round-robin grant with a debug-port lock; combinational (0-cycle) grant.
// No buffering: a requester that is not granted must hold its request until it is.
module ldst_rr_lock
    import ldst_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       p0_req_i,
    input  logic       p1_req_i,
    input  logic       p1_lock_i,
    output logic [1:0] gnt_oh_o
);

    lock_state_t lock_q, lock_d;
    port_id_t    last_q, last_d;
    logic [1:0]  gnt_oh;

    // Grants are forced low during reset so nothing reaches the memory bus.
    always_comb begin
        gnt_oh = 2'b00;
        if (reset) begin
            gnt_oh = 2'b00;
        end else if (lock_q == LK_LOCKED_P1) begin
            gnt_oh = {p1_req_i, 1'b0};
        end else if (p0_req_i && p1_req_i) begin
            gnt_oh = (last_q == PORT_P1) ? 2'b01 : 2'b10;
        end else begin
            gnt_oh = {p1_req_i, p0_req_i};
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_oh != 2'b00) begin
            last_d = oh_to_port(gnt_oh);
        end

        lock_d = lock_q;
        case (lock_q)
            LK_UNLOCKED: begin
                if (gnt_oh[1] && p1_lock_i) begin
                    lock_d = LK_LOCKED_P1;
                end
            end
            LK_LOCKED_P1: begin
                if (!p1_lock_i) begin
                    lock_d = LK_UNLOCKED;
                end
            end
            default: lock_d = LK_UNLOCKED;
        endcase
    end

    // last_q resets to port 1 so port 0 wins the first contention.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_q <= LK_UNLOCKED;
            last_q <= PORT_P1;
        end else begin
            lock_q <= lock_d;
            last_q <= last_d;
        end
    end

    assign gnt_oh_o = gnt_oh;

endmodule

// File: rtl/ldst_mem_arbiter.sv
// Arbitrates a sequencer port and a debug port onto one synchronous RAM; grant and
// memory strobes are same-cycle, read data returns one cycle later; no request buffering.
module ldst_mem_arbiter
    import ldst_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic                  p1_lock,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic [1:0] gnt_oh;
    rtag_t      tag_q, tag_d;

    ldst_rr_lock u_rr_lock (
        .clock     (clock),
        .reset     (reset),
        .p0_req_i  (p0_req),
        .p1_req_i  (p1_req),
        .p1_lock_i (p1_lock),
        .gnt_oh_o  (gnt_oh)
    );

    assign p0_gnt = gnt_oh[0];
    assign p1_gnt = gnt_oh[1];

    // Idle bus is driven to all-zero rather than holding the last address.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_oh[0]) begin
            mem_en    = 1'b1;
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (gnt_oh[1]) begin
            mem_en    = 1'b1;
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
    end

    always_comb begin
        tag_d      = '0;
        tag_d.vld  = mem_en & ~mem_we;
        tag_d.port = oh_to_port(gnt_oh);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign p0_rvalid = tag_q.vld && (tag_q.port == PORT_P0) && !reset;
    assign p1_rvalid = tag_q.vld && (tag_q.port == PORT_P1) && !reset;
    assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
    assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_ldst_mem_arbiter.sv
// Directed bench for ldst_mem_arbiter with a synchronous RAM model and a read-return scoreboard.
module tb_ldst_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          p0_req = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_wr [logic [AW-1:0]];
    logic          exp_last = 1'b1;
    int            errors = 0;
    int            checks = 0;
    int            n0 = 0, n1 = 0, both = 0;

    always #5 clock = ~clock;

    ldst_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_lock   (p1_lock),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [DW-1:0] preload(input logic [AW-1:0] a);
        case (a)
            16'h0010: return 8'hA5;
            16'h0020: return 8'h5A;
            16'h0021: return 8'h5B;
            16'h0022: return 8'h5C;
            16'h0023: return 8'h5D;
            default:  return 8'h00;
        endcase
    endfunction

    // Synchronous single-port RAM model.
    logic [DW-1:0] ram [0:65535];
    bit            wr_seen [0:65535];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]     <= mem_wdata;
                wr_seen[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= wr_seen[mem_addr] ? ram[mem_addr] : preload(mem_addr);
            end
        end
    end

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (ref_wr.exists(a)) return ref_wr[a];
        return preload(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rv(input string tag);
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, ".p0_rvalid"}, 32'(p0_rvalid), 32'(e.port == 1'b0));
            chk({tag, ".p1_rvalid"}, 32'(p1_rvalid), 32'(e.port == 1'b1));
            chk({tag, ".p0_rdata"},  32'(p0_rdata),  32'((e.port == 1'b0) ? e.data : 8'h00));
            chk({tag, ".p1_rdata"},  32'(p1_rdata),  32'((e.port == 1'b1) ? e.data : 8'h00));
        end else begin
            chk({tag, ".p0_rvalid"}, 32'(p0_rvalid), 32'd0);
            chk({tag, ".p1_rvalid"}, 32'(p1_rvalid), 32'd0);
            chk({tag, ".p0_rdata"},  32'(p0_rdata),  32'd0);
            chk({tag, ".p1_rdata"},  32'(p1_rdata),  32'd0);
        end
    endtask

    task automatic drv0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic lock);
        p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; p1_lock = lock;
    endtask

    // Inputs are driven at the falling edge; outputs sampled 1 time unit later.
    task automatic step(input string tag, input logic eg0, input logic eg1);
        exp_t          e;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        #1;
        check_rv(tag);
        chk({tag, ".p0_gnt"}, 32'(p0_gnt), 32'(eg0));
        chk({tag, ".p1_gnt"}, 32'(p1_gnt), 32'(eg1));
        if (eg0 || eg1) begin
            we = eg1 ? p1_we    : p0_we;
            a  = eg1 ? p1_addr  : p0_addr;
            d  = eg1 ? p1_wdata : p0_wdata;
            chk({tag, ".mem_en"},    32'(mem_en),    32'd1);
            chk({tag, ".mem_we"},    32'(mem_we),    32'(we));
            chk({tag, ".mem_addr"},  32'(mem_addr),  32'(a));
            chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(d));
            if (we) begin
                ref_wr[a] = d;
            end else begin
                e.port = eg1;
                e.data = exp_data(a);
                exp_q.push_back(e);
            end
            exp_last = eg1;
        end else begin
            chk({tag, ".mem_en"},    32'(mem_en),    32'd0);
            chk({tag, ".mem_we"},    32'(mem_we),    32'd0);
            chk({tag, ".mem_addr"},  32'(mem_addr),  32'd0);
            chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
        end
        if (p0_gnt) n0++;
        if (p1_gnt) n1++;
        if (p0_gnt && p1_gnt) both++;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        // Reset with both ports requesting: everything must stay quiet.
        reset = 1'b1;
        drv0(1'b1, 1'b0, 16'h0010, 8'h00);
        drv1(1'b1, 1'b0, 16'h0020, 8'h00, 1'b0);
        @(negedge clock);
        step("rst0", 1'b0, 1'b0);
        step("rst1", 1'b0, 1'b0);

        // Contention after reset: p0 first, then p1; data returns a cycle later.
        reset = 1'b0;
        exp_last = 1'b1;
        step("t1c0", 1'b1, 1'b0);
        drv0(1'b0, 1'b0, 16'h0000, 8'h00);
        step("t1c1", 1'b0, 1'b1);
        drv1(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        step("t1c2", 1'b0, 1'b0);

        // Write then read back on p0.
        drv0(1'b1, 1'b1, 16'h1234, 8'h3C);
        step("t2wr", 1'b1, 1'b0);
        drv0(1'b1, 1'b0, 16'h1234, 8'h00);
        step("t2rd", 1'b1, 1'b0);
        drv0(1'b0, 1'b0, 16'h0000, 8'h00);
        step("t2idle", 1'b0, 1'b0);

        // Locked burst of 4 p1 reads while p0 waits; lock drops with the 4th read.
        drv0(1'b1, 1'b0, 16'h0010, 8'h00);
        drv1(1'b1, 1'b0, 16'h0020, 8'h00, 1'b1);
        step("t3l0", 1'b0, 1'b1);
        drv1(1'b1, 1'b0, 16'h0021, 8'h00, 1'b1);
        step("t3l1", 1'b0, 1'b1);
        drv1(1'b1, 1'b0, 16'h0022, 8'h00, 1'b1);
        step("t3l2", 1'b0, 1'b1);
        drv1(1'b1, 1'b0, 16'h0023, 8'h00, 1'b0);
        step("t3l3", 1'b0, 1'b1);
        drv1(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        step("t3rel", 1'b1, 1'b0);
        drv0(1'b0, 1'b0, 16'h0000, 8'h00);
        step("t3idle", 1'b0, 1'b0);

        // Lock held with no p1 request still blocks p0.
        drv0(1'b1, 1'b0, 16'h0010, 8'h00);
        drv1(1'b1, 1'b0, 16'h0022, 8'h00, 1'b1);
        step("t4lk", 1'b0, 1'b1);
        drv1(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        step("t4h0", 1'b0, 1'b0);
        step("t4h1", 1'b0, 1'b0);
        drv1(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        step("t4h2", 1'b0, 1'b0);
        step("t4rel", 1'b1, 1'b0);

        // 100 cycles of contention without lock: strict alternation.
        n0 = 0; n1 = 0; both = 0;
        drv0(1'b1, 1'b0, 16'h0010, 8'h00);
        drv1(1'b1, 1'b0, 16'h0020, 8'h00, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step($sformatf("t5c%0d", i), exp_last, !exp_last);
        end
        drv0(1'b0, 1'b0, 16'h0000, 8'h00);
        drv1(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        chk("t5.n0", 32'(n0), 32'd50);
        chk("t5.n1", 32'(n1), 32'd50);
        chk("t5.both", 32'(both), 32'd0);
        step("t5idle", 1'b0, 1'b0);

        // Reset one cycle after a locked p1 read grant.
        drv1(1'b1, 1'b0, 16'h0021, 8'h00, 1'b1);
        step("t6lk", 1'b0, 1'b1);
        reset = 1'b1;
        exp_q.delete();
        drv0(1'b1, 1'b0, 16'h0010, 8'h00);
        drv1(1'b1, 1'b0, 16'h0020, 8'h00, 1'b1);
        step("t6rst", 1'b0, 1'b0);
        reset = 1'b0;
        exp_last = 1'b1;
        drv1(1'b1, 1'b0, 16'h0020, 8'h00, 1'b0);
        step("t6c0", 1'b1, 1'b0);
        drv0(1'b0, 1'b0, 16'h0000, 8'h00);
        step("t6c1", 1'b0, 1'b1);
        drv1(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        step("t6c2", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
